// File: rtl/sync_pkg.sv
// Shared constants and helpers for the sync_filter block: legal parameter
// ranges and the debounce counter width calculation.
package sync_pkg;

    localparam int STAGES_MIN   = 2;
    localparam int STAGES_MAX   = 8;
    localparam int DEBOUNCE_MIN = 1;
    localparam int DEBOUNCE_MAX = 65535;

    // Ceiling log2, never less than 1 bit so a counter always has a width.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((64'd1 << w) < 64'(n)) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

    // Counter width able to hold 0..DEBOUNCE.
    function automatic int cnt_width(input int debounce);
        return clog2(debounce + 1);
    endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel of sync_filter: a plain flip-flop synchroniser chain, a
// debounce counter that qualifies level changes, and registered edge pulses.
module sync_filter_ch
    import sync_pkg::*;
#(
    parameter int   STAGES    = 3,
    parameter int   DEBOUNCE  = 1,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic input_sig_i,
    output logic sync_sig_o,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int              CNT_W    = cnt_width(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic [STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              level_q, level_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              sync_now;

    assign sync_now = sync_q[STAGES-1];

    // Next state: shift the chain, count consecutive samples that disagree
    // with the current level, and commit the new level on the last one.
    always_comb begin
        sync_d  = {sync_q[STAGES-2:0], input_sig_i};
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_now == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = sync_now;
            rise_d  = sync_now;
            fall_d  = ~sync_now;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset discards any partial count and pending pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q  <= {STAGES{RESET_VAL}};
            cnt_q   <= '0;
            level_q <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign sync_sig_o = sync_now;
    assign level_o    = level_q;
    assign rise_o     = rise_q;
    assign fall_o     = fall_q;

endmodule

// File: rtl/sync_filter.sv
// Multi-channel input synchroniser with debounce and edge detection.
// Channels are fully independent; each is one sync_filter_ch instance.
module sync_filter
    import sync_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = 3,
    parameter int               DEBOUNCE  = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] input_sig,
    output logic [WIDTH-1:0] sync_sig,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("sync_filter: STAGES=%0d outside %0d..%0d", STAGES, STAGES_MIN, STAGES_MAX);
    end

    if (DEBOUNCE < DEBOUNCE_MIN || DEBOUNCE > DEBOUNCE_MAX) begin : g_bad_debounce
        $error("sync_filter: DEBOUNCE=%0d outside %0d..%0d", DEBOUNCE, DEBOUNCE_MIN, DEBOUNCE_MAX);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        sync_filter_ch #(
            .STAGES    (STAGES),
            .DEBOUNCE  (DEBOUNCE),
            .RESET_VAL (RESET_VAL[i])
        ) u_ch (
            .clk         (clk),
            .resetn      (resetn),
            .input_sig_i (input_sig[i]),
            .sync_sig_o  (sync_sig[i]),
            .level_o     (level[i]),
            .rise_o      (rise[i]),
            .fall_o      (fall[i])
        );
    end

endmodule

// File: tb/tb_sync_filter.sv
// Bench for sync_filter: two instances (DEBOUNCE=4 and DEBOUNCE=1) share the
// same inputs and are checked every cycle against a run-length model, plus
// directed scenarios with hand-computed expectations.
module tb_sync_filter;

    localparam int W = 2;
    localparam int S = 3;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [W-1:0] input_sig = '0;

    logic [W-1:0] sync_a, level_a, rise_a, fall_a;
    logic [W-1:0] sync_b, level_b, rise_b, fall_b;

    always #5 clk = ~clk;

    sync_filter #(.WIDTH(W), .STAGES(S), .DEBOUNCE(4), .RESET_VAL(2'b00)) dut_a (
        .clk(clk), .resetn(resetn), .input_sig(input_sig),
        .sync_sig(sync_a), .level(level_a), .rise(rise_a), .fall(fall_a)
    );

    sync_filter #(.WIDTH(W), .STAGES(S), .DEBOUNCE(1), .RESET_VAL(2'b00)) dut_b (
        .clk(clk), .resetn(resetn), .input_sig(input_sig),
        .sync_sig(sync_b), .level(level_b), .rise(rise_b), .fall(fall_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. m_hist[0] is the newest sample of input_sig taken at a
    // clock edge; the synchronised value is the sample from S edges ago.
    // For each instance k, m_run counts how many consecutive edges the
    // synchronised value has disagreed with the filtered level.
    logic [W-1:0] m_hist[S];
    logic [W-1:0] m_level[2];
    logic [W-1:0] m_rise[2];
    logic [W-1:0] m_fall[2];
    int           m_run[2][W];

    always @(posedge clk) begin
        logic [W-1:0] seen;
        int db;
        seen = m_hist[S-1];
        if (!resetn) begin
            for (int i = 0; i < S; i++) m_hist[i] = '0;
            for (int k = 0; k < 2; k++) begin
                m_level[k] = '0;
                m_rise[k]  = '0;
                m_fall[k]  = '0;
                for (int c = 0; c < W; c++) m_run[k][c] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                db = (k == 0) ? 4 : 1;
                m_rise[k] = '0;
                m_fall[k] = '0;
                for (int c = 0; c < W; c++) begin
                    if (seen[c] !== m_level[k][c]) begin
                        m_run[k][c] = m_run[k][c] + 1;
                        if (m_run[k][c] == db) begin
                            m_level[k][c] = seen[c];
                            m_run[k][c] = 0;
                            if (seen[c]) m_rise[k][c] = 1'b1;
                            else         m_fall[k][c] = 1'b1;
                        end
                    end else begin
                        m_run[k][c] = 0;
                    end
                end
            end
            for (int i = S - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = input_sig;
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("a_sync",  32'(sync_a),  32'(m_hist[S-1]));
            chk("a_level", 32'(level_a), 32'(m_level[0]));
            chk("a_rise",  32'(rise_a),  32'(m_rise[0]));
            chk("a_fall",  32'(fall_a),  32'(m_fall[0]));
            chk("a_excl",  32'(rise_a & fall_a), 32'd0);
            chk("b_sync",  32'(sync_b),  32'(m_hist[S-1]));
            chk("b_level", 32'(level_b), 32'(m_level[1]));
            chk("b_rise",  32'(rise_b),  32'(m_rise[1]));
            chk("b_fall",  32'(fall_b),  32'(m_fall[1]));
            chk("b_excl",  32'(rise_b & fall_b), 32'd0);
        end
    end

    initial begin
        int n_sync, n_lvl, n_rise, n_fall, rise_at, fall_at;
        logic [W-1:0] prev_sync;
        int hold[W];

        // Reset with inputs high: everything must read zero.
        resetn    = 1'b0;
        input_sig = 2'b11;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_sync",  32'(sync_a),  32'd0);
        chk("rst_level", 32'(level_a), 32'd0);
        chk("rst_rise",  32'(rise_a),  32'd0);
        chk("rst_fall",  32'(fall_a),  32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        chk("rel_sync_e2", 32'(sync_a), 32'h0);
        @(negedge clk);
        chk("rel_sync_e3", 32'(sync_a), 32'h3);
        @(negedge clk);
        chk("rel_b_level_e4", 32'(level_b), 32'h3);
        chk("rel_b_rise_e4",  32'(rise_b),  32'h3);
        chk("rel_a_level_e4", 32'(level_a), 32'h0);
        repeat (2) @(negedge clk);
        chk("rel_level_e6", 32'(level_a), 32'h0);
        @(negedge clk);
        chk("rel_level_e7", 32'(level_a), 32'h3);
        chk("rel_rise_e7",  32'(rise_a),  32'h3);
        @(negedge clk);
        chk("rel_rise_e8",  32'(rise_a),  32'h0);

        // Glitch of 3 cycles on channel 0 must not reach level.
        input_sig = 2'b00;
        repeat (12) @(negedge clk);
        input_sig = 2'b01;
        n_sync = 0; n_lvl = 0; n_rise = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 3) input_sig = 2'b00;
            if (sync_a[0])  n_sync++;
            if (level_a[0]) n_lvl++;
            if (rise_a[0])  n_rise++;
        end
        chk("glitch_sync_cycles", 32'(n_sync), 32'd3);
        chk("glitch_level",       32'(n_lvl),  32'd0);
        chk("glitch_rise",        32'(n_rise), 32'd0);

        // Exactly 4 cycles high: rise at edge 7, fall 7 edges after return low.
        input_sig = 2'b01;
        n_rise = 0; n_fall = 0; rise_at = -1; fall_at = -1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 4) input_sig = 2'b00;
            if (rise_a[0]) begin n_rise++; rise_at = i; end
            if (fall_a[0]) begin n_fall++; fall_at = i; end
        end
        chk("thr_rise_count", 32'(n_rise), 32'd1);
        chk("thr_rise_edge",  32'(rise_at), 32'd7);
        chk("thr_fall_count", 32'(n_fall), 32'd1);
        chk("thr_fall_edge",  32'(fall_at), 32'd11);

        // Channel 0 rises while channel 1 falls.
        input_sig = 2'b10;
        repeat (12) @(negedge clk);
        input_sig = 2'b01;
        repeat (6) @(negedge clk);
        chk("simul_level_e6", 32'(level_a), 32'h2);
        @(negedge clk);
        chk("simul_rise", 32'(rise_a),  32'h1);
        chk("simul_fall", 32'(fall_a),  32'h2);
        chk("simul_level", 32'(level_a), 32'h1);

        // Reset in the middle of a count.
        input_sig = 2'b00;
        repeat (12) @(negedge clk);
        input_sig = 2'b01;
        repeat (6) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("midrst_level", 32'(level_a), 32'h0);
        chk("midrst_pulse", 32'(rise_a | fall_a), 32'h0);
        resetn = 1'b1;
        @(negedge clk);
        chk("midrst_after_pulse", 32'(rise_a | fall_a), 32'h0);
        repeat (5) @(negedge clk);
        chk("midrst_level_e13", 32'(level_a), 32'h0);
        @(negedge clk);
        chk("midrst_level_e14", 32'(level_a), 32'h1);
        chk("midrst_rise_e14",  32'(rise_a),  32'h1);

        // DEBOUNCE=1: level follows sync one edge later while toggling.
        input_sig = 2'b00;
        repeat (8) @(negedge clk);
        prev_sync = sync_b;
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) input_sig[0] = ~input_sig[0];
            @(negedge clk);
            chk("b_follow", 32'(level_b), 32'(prev_sync));
            prev_sync = sync_b;
        end

        // Randomised hold times on each channel with occasional resets.
        for (int c = 0; c < W; c++) hold[c] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < W; c++) begin
                if (hold[c] == 0) begin
                    input_sig[c] = 1'($urandom_range(0, 1));
                    hold[c] = int'($urandom_range(1, 7));
                end else begin
                    hold[c]--;
                end
            end
            resetn = ($urandom_range(0, 149) != 0);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_filter.md
SYNC_FILTER -- requirements
Module: sync_filter

Interface
REQ-001 Parameter WIDTH, default 1: number of independent channels.
REQ-002 Parameter STAGES, default 3: synchroniser flip-flop depth per channel; legal range 2..8.
REQ-003 Parameter DEBOUNCE, default 1: consecutive stable cycles required before the filtered level changes; legal range 1..65535; 1 means no filtering.
REQ-004 Parameter RESET_VAL, default 0 (WIDTH bits): per-channel reset value of all synchroniser stages and of level.
REQ-005 clk  input  1  clock; the single clock domain of the block.
REQ-006 resetn  input  1  reset, synchronous, active-low.
REQ-007 input_sig  input  WIDTH  asynchronous inputs, one bit per channel.
REQ-008 sync_sig  output  WIDTH  raw synchronised value (last synchroniser stage).
REQ-009 level  output  WIDTH  debounced, registered level.
REQ-010 rise  output  WIDTH  one-cycle pulse when level goes 0->1.
REQ-011 fall  output  WIDTH  one-cycle pulse when level goes 1->0.

Function
REQ-012 Each channel SHALL be fully independent; no cross-channel logic.
REQ-013 sync_sig SHALL equal input_sig as sampled STAGES rising edges earlier: a shift of STAGES flip-flops with no logic between stages.
REQ-014 Each channel SHALL hold a counter cnt of width clog2(DEBOUNCE+1), reset to 0.
REQ-015 If sync_sig == level in a cycle, cnt SHALL clear to 0 at the next edge.
REQ-016 If sync_sig != level and cnt < DEBOUNCE-1, cnt SHALL increment by 1.
REQ-017 If sync_sig != level and cnt == DEBOUNCE-1, level SHALL take sync_sig at the next edge and cnt SHALL clear.
REQ-018 Consequence of REQ-015..017: level changes only after DEBOUNCE consecutive differing samples; end-to-end latency from input_sig to level is STAGES+DEBOUNCE edges.
REQ-019 Any run of differing samples shorter than DEBOUNCE SHALL leave level unchanged, with no rise or fall pulse.
REQ-020 cnt SHALL never exceed DEBOUNCE-1 and SHALL never wrap.
REQ-021 rise and fall SHALL be registered and asserted in exactly the cycle in which level first shows its new value, for one cycle only.
REQ-022 rise and fall SHALL never be asserted together on the same channel.
REQ-023 Elaboration SHALL fail if STAGES < 2 or DEBOUNCE < 1.

Reset
REQ-024 While resetn is low at a clock edge: all synchroniser stages and level SHALL load RESET_VAL, cnt SHALL load 0, and rise and fall SHALL load 0.
REQ-025 After reset release, a differing input SHALL be debounced normally; no pulse is generated by reset itself.
REQ-026 Reset asserted mid-count SHALL discard the partial count; no pulse is produced in the cycle reset is applied or the cycle after.

Structure
REQ-027 Package sync_pkg SHALL hold the clog2 counter-width function and the STAGES/DEBOUNCE legal-range constants.
REQ-028 One sub-module, sync_filter_ch (single-channel chain, counter and edge logic), SHALL be instantiated WIDTH times by a generate loop.

Verification (WIDTH=2, STAGES=3, DEBOUNCE=4, RESET_VAL=0 unless stated)
REQ-029 Reset: input_sig=11 with resetn low for 2 cycles -> all outputs 0. After release -> sync_sig=11 after 3 edges, level=11 and rise=11 after 4 more edges, with rise high for 1 cycle.
REQ-030 Glitch: channel 0 at level 0, input high for 3 cycles -> sync_sig high for 3 cycles; level stays 0; rise stays 0.
REQ-031 Threshold: channel 0 input high for exactly 4 cycles -> level=1 at edge 7 after the change and rise pulses once; after the input returns low, fall pulses 7 edges later.
REQ-032 Simultaneous: channel 0 rising while channel 1 falling with aligned timing -> rise=01 and fall=10 in the same cycle.
REQ-033 Reset mid-count: channel 0 cnt=3, resetn low for 1 cycle -> level=0, cnt=0, no pulse; a subsequent stable input needs the full 4 cycles.
REQ-034 DEBOUNCE=1: input toggling every 2 cycles -> level follows sync_sig one edge later, with alternating single-cycle rise and fall pulses.
